orv64_pmp_check_arb: RTL and testbench

- Shares one combinational PMP checker between N_REQ requesters: IFU fetch, LSU load/store and the PTW walker.
- Arbitrates round-robin, latches the winning request and drives the checker for one cycle.
- Registers the checker's exception result and returns it to the winner over a valid/ready response channel.
- Sits between the requesters and the single PMP checker instance in the orv64 core.

---
 rtl/orv64_pmp_check_arb_pkg.sv | 48 ++++
 rtl/orv64_rr_arb.sv | 40 ++++
 rtl/orv64_pmp_check_arb.sv | 185 ++++++++++++++++++
 tb/tb_orv64_pmp_check_arb.sv | 556 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/orv64_pmp_check_arb_pkg.sv
// Shared parameters and types for the orv64 PMP check arbiter.
// orv64_param_pkg holds the sizing constants and requester indices.
// orv64_typedef_pkg holds the address, access, cause, FSM and request types.
package orv64_param_pkg;

    localparam int ORV64_PHY_ADDR_WIDTH = 56;
    localparam int CPU_DATA_BYTES       = 8;

    // Requesters sharing the PMP checker
    localparam int ORV64_PMP_N_REQ   = 3;
    localparam int ORV64_PMP_REQ_IFU = 0;
    localparam int ORV64_PMP_REQ_LSU = 1;
    localparam int ORV64_PMP_REQ_PTW = 2;

endpackage

package orv64_typedef_pkg;

    import orv64_param_pkg::*;

    typedef logic [ORV64_PHY_ADDR_WIDTH-1:0] orv64_paddr_t;
    typedef logic [CPU_DATA_BYTES-1:0]       cpu_byte_mask_t;
    typedef logic [3:0]                      orv64_excp_cause_t;

    typedef enum logic [1:0] {
        ORV64_ACCESS_FETCH = 2'd0,
        ORV64_ACCESS_LOAD  = 2'd1,
        ORV64_ACCESS_STORE = 2'd2
    } orv64_access_type_t;

    // Access-fault causes the PMP checker can report
    localparam orv64_excp_cause_t ORV64_EXCP_CAUSE_INST_ACCESS_FAULT  = 4'd1;
    localparam orv64_excp_cause_t ORV64_EXCP_CAUSE_LOAD_ACCESS_FAULT  = 4'd5;
    localparam orv64_excp_cause_t ORV64_EXCP_CAUSE_STORE_ACCESS_FAULT = 4'd7;

    typedef enum logic [1:0] {
        ORV64_PMP_ARB_IDLE  = 2'd0,
        ORV64_PMP_ARB_CHECK = 2'd1,
        ORV64_PMP_ARB_RESP  = 2'd2
    } orv64_pmp_arb_state_e;

    typedef struct packed {
        orv64_paddr_t       paddr;
        orv64_access_type_t access_type;
        cpu_byte_mask_t     byte_mask;
    } orv64_pmp_chk_req_t;

endpackage

// File: rtl/orv64_rr_arb.sv
// orv64_rr_arb: round-robin one-hot grant among N_REQ requesters.
// The search starts at ptr_i and wraps modulo N_REQ; ptr_i must be < N_REQ.
module orv64_rr_arb #(
    parameter int N_REQ = 3,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0] gnt_idx_o,
    output logic             gnt_valid_o
);

    // Scan candidates ptr_i, ptr_i+1, ... and grant the first valid one.
    always_comb begin
        logic [PTR_W:0]   cand;
        logic [PTR_W-1:0] cand_idx;
        logic             found;
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        gnt_o     = '0;
        gnt_idx_o = '0;
        cand      = '0;
        cand_idx  = '0;
        found     = 1'b0;
        for (int off = 0; off < N_REQ; off++) begin
            cand = {1'b0, ptr_i} + (PTR_W+1)'(off);
            if (cand >= (PTR_W+1)'(N_REQ)) begin
                cand = cand - (PTR_W+1)'(N_REQ);
            end
            cand_idx = cand[PTR_W-1:0];
            if (!found && valid_i[cand_idx]) begin
                gnt_o[cand_idx] = 1'b1;
                gnt_idx_o       = cand_idx;
                found           = 1'b1;
            end
        end
        gnt_valid_o = found;
    end

endmodule

// File: rtl/orv64_pmp_check_arb.sv
// orv64_pmp_check_arb: shares one combinational PMP checker between the IFU,
// LSU and PTW. A round-robin winner is latched, checked for one cycle, and
// its registered fault result is returned over a one-hot valid/ready channel.
// One check every three cycles at best: IDLE (accept) -> CHECK -> RESP.
// Optional: define ORV64_PMP_ARB_FAULT_CNT_EN to add saturating per-requester
// fault counters on output fault_cnt.
module orv64_pmp_check_arb
    import orv64_param_pkg::*;
    import orv64_typedef_pkg::*;
#(
    parameter int N_REQ = ORV64_PMP_N_REQ,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [N_REQ-1:0]                    req_valid,
    output logic [N_REQ-1:0]                    req_ready,
    input  orv64_paddr_t       [N_REQ-1:0]      req_paddr,
    input  orv64_access_type_t [N_REQ-1:0]      req_access_type,
    input  cpu_byte_mask_t     [N_REQ-1:0]      req_byte_mask,
    output logic [N_REQ-1:0]                    resp_valid,
    input  logic [N_REQ-1:0]                    resp_ready,
    output logic                                resp_excp_valid,
    output orv64_excp_cause_t                   resp_excp_cause,
    input  logic                                pmp_cfg_chg,
    input  logic                                kill,
    output logic                                chk_paddr_valid,
    output orv64_paddr_t                        chk_paddr,
    output orv64_access_type_t                  chk_access_type,
    output cpu_byte_mask_t                      chk_byte_mask,
    input  logic                                chk_excp_valid,
    input  orv64_excp_cause_t                   chk_excp_cause
`ifdef ORV64_PMP_ARB_FAULT_CNT_EN
    ,
    output logic [N_REQ-1:0][15:0]              fault_cnt
`endif
);

    orv64_pmp_arb_state_e state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]     gnt_q, gnt_d;
    orv64_pmp_chk_req_t   req_q, req_d;
    logic                 resp_excp_valid_q, resp_excp_valid_d;
    orv64_excp_cause_t    resp_excp_cause_q, resp_excp_cause_d;

    logic [N_REQ-1:0]     arb_gnt;
    logic [PTR_W-1:0]     arb_gnt_idx;
    logic                 arb_gnt_valid;
    logic                 req_open;
    logic                 accept;
    logic                 chk_capture;
    logic                 resp_hsk;

    orv64_rr_arb #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arb (
        .valid_i     (req_valid),
        .ptr_i       (rr_ptr_q),
        .gnt_o       (arb_gnt),
        .gnt_idx_o   (arb_gnt_idx),
        .gnt_valid_o (arb_gnt_valid)
    );

    // Requests are only offered in IDLE, and never while a flush or a PMP
    // CSR write is in progress, so a new check always sees settled CSRs.
    assign req_open    = (state_q == ORV64_PMP_ARB_IDLE) && !kill && !pmp_cfg_chg && !rst;
    assign accept      = req_open && arb_gnt_valid;
    // A CSR change during CHECK discards the result; the next cycle re-checks.
    assign chk_capture = (state_q == ORV64_PMP_ARB_CHECK) && !kill && !pmp_cfg_chg;
    // Only the granted requester's resp_ready completes the response.
    assign resp_hsk    = (state_q == ORV64_PMP_ARB_RESP) && resp_ready[gnt_q];

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments; rst is synchronous.
        if (rst) begin
            state_q <= ORV64_PMP_ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; kill outranks a CSR change in CHECK.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ORV64_PMP_ARB_IDLE: begin
                if (accept) state_d = ORV64_PMP_ARB_CHECK;
            end
            ORV64_PMP_ARB_CHECK: begin
                if (kill)              state_d = ORV64_PMP_ARB_IDLE;
                else if (!pmp_cfg_chg) state_d = ORV64_PMP_ARB_RESP;
            end
            ORV64_PMP_ARB_RESP: begin
                if (kill || resp_hsk) state_d = ORV64_PMP_ARB_IDLE;
            end
            default: state_d = ORV64_PMP_ARB_IDLE;
        endcase
    end

    // FSM outputs: everything except req_ready is a pure function of state.
    always_comb begin
        req_ready       = req_open ? arb_gnt : '0;
        resp_valid      = '0;
        resp_excp_valid = 1'b0;
        resp_excp_cause = '0;
        chk_paddr_valid = 1'b0;
        chk_paddr       = '0;
        chk_access_type = ORV64_ACCESS_FETCH;
        chk_byte_mask   = '0;
        if (state_q == ORV64_PMP_ARB_CHECK) begin
            chk_paddr_valid = 1'b1;
            chk_paddr       = req_q.paddr;
            chk_access_type = req_q.access_type;
            chk_byte_mask   = req_q.byte_mask;
        end
        if (state_q == ORV64_PMP_ARB_RESP) begin
            resp_valid[gnt_q] = 1'b1;
            resp_excp_valid   = resp_excp_valid_q;
            resp_excp_cause   = resp_excp_cause_q;
        end
    end

    // Datapath next state: latch the winner on accept, the result on capture.
    always_comb begin
        rr_ptr_d          = rr_ptr_q;
        gnt_d             = gnt_q;
        req_d             = req_q;
        resp_excp_valid_d = resp_excp_valid_q;
        resp_excp_cause_d = resp_excp_cause_q;
        if (accept) begin
            gnt_d             = arb_gnt_idx;
            rr_ptr_d          = (arb_gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : arb_gnt_idx + 1'b1;
            req_d.paddr       = req_paddr[arb_gnt_idx];
            req_d.access_type = req_access_type[arb_gnt_idx];
            req_d.byte_mask   = req_byte_mask[arb_gnt_idx];
        end
        if (chk_capture) begin
            resp_excp_valid_d = chk_excp_valid;
            resp_excp_cause_d = chk_excp_cause;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q          <= '0;
            gnt_q             <= '0;
            req_q             <= '0;
            resp_excp_valid_q <= 1'b0;
            resp_excp_cause_q <= '0;
        end else begin
            rr_ptr_q          <= rr_ptr_d;
            gnt_q             <= gnt_d;
            req_q             <= req_d;
            resp_excp_valid_q <= resp_excp_valid_d;
            resp_excp_cause_q <= resp_excp_cause_d;
        end
    end

`ifdef ORV64_PMP_ARB_FAULT_CNT_EN
    logic [N_REQ-1:0][15:0] fault_cnt_q, fault_cnt_d;

    // Count delivered faults per requester, saturating at all-ones.
    always_comb begin
        fault_cnt_d = fault_cnt_q;
        if (resp_hsk && resp_excp_valid_q && (fault_cnt_q[gnt_q] != 16'hFFFF)) begin
            fault_cnt_d[gnt_q] = fault_cnt_q[gnt_q] + 16'd1;
        end
    end

    // Fault counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_cnt_q <= '0;
        end else begin
            fault_cnt_q <= fault_cnt_d;
        end
    end

    assign fault_cnt = fault_cnt_q;
`endif

endmodule

// File: tb/tb_orv64_pmp_check_arb.sv
// Self-checking bench for orv64_pmp_check_arb. A small PMP checker model
// answers the DUT's chk_* request; expected responses are queued when a
// request is accepted and compared when the DUT returns them.
module tb_orv64_pmp_check_arb;

    import orv64_param_pkg::*;
    import orv64_typedef_pkg::*;

    localparam int N = ORV64_PMP_N_REQ;

    logic                         clk = 1'b0;
    logic                         rst;
    logic [N-1:0]                 req_valid, req_ready, resp_valid, resp_ready;
    orv64_paddr_t       [N-1:0]   req_paddr;
    orv64_access_type_t [N-1:0]   req_access_type;
    cpu_byte_mask_t     [N-1:0]   req_byte_mask;
    logic                         resp_excp_valid;
    orv64_excp_cause_t            resp_excp_cause;
    logic                         pmp_cfg_chg, kill;
    logic                         chk_paddr_valid;
    orv64_paddr_t                 chk_paddr;
    orv64_access_type_t           chk_access_type;
    cpu_byte_mask_t               chk_byte_mask;
    logic                         chk_excp_valid;
    orv64_excp_cause_t            chk_excp_cause;
`ifdef ORV64_PMP_ARB_FAULT_CNT_EN
    logic [N-1:0][15:0]           fault_cnt;
`endif

    typedef struct {
        int                gnt;
        logic              ev;
        orv64_excp_cause_t cause;
    } exp_t;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   model_ptr = 0;
    int   exp_fcnt[N];
    bit   deny      = 1'b1;

    orv64_pmp_check_arb dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_paddr       (req_paddr),
        .req_access_type (req_access_type),
        .req_byte_mask   (req_byte_mask),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_excp_valid (resp_excp_valid),
        .resp_excp_cause (resp_excp_cause),
        .pmp_cfg_chg     (pmp_cfg_chg),
        .kill            (kill),
        .chk_paddr_valid (chk_paddr_valid),
        .chk_paddr       (chk_paddr),
        .chk_access_type (chk_access_type),
        .chk_byte_mask   (chk_byte_mask),
        .chk_excp_valid  (chk_excp_valid),
        .chk_excp_cause  (chk_excp_cause)
`ifdef ORV64_PMP_ARB_FAULT_CNT_EN
        ,
        .fault_cnt       (fault_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model helpers ----------------
    function automatic logic would_fault(orv64_paddr_t a, bit d);
        return d && (a >= 56'h0000_0000_8000_0000);
    endfunction

    function automatic orv64_excp_cause_t fault_cause(orv64_access_type_t t);
        case (t)
            ORV64_ACCESS_FETCH: return ORV64_EXCP_CAUSE_INST_ACCESS_FAULT;
            ORV64_ACCESS_LOAD:  return ORV64_EXCP_CAUSE_LOAD_ACCESS_FAULT;
            default:            return ORV64_EXCP_CAUSE_STORE_ACCESS_FAULT;
        endcase
    endfunction

    function automatic int rr_pick(logic [N-1:0] v, int ptr);
        for (int off = 0; off < N; off++) begin
            if (v[(ptr + off) % N]) return (ptr + off) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(int i);
        logic [N-1:0] r;
        r = '0;
        if (i >= 0 && i < N) r[i] = 1'b1;
        return r;
    endfunction

    function automatic int oh_idx(logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // PMP checker model: denies everything at or above 0x8000_0000 while deny is set.
    always_comb begin
        chk_excp_valid = 1'b0;
        chk_excp_cause = '0;
        if (chk_paddr_valid && would_fault(chk_paddr, deny)) begin
            chk_excp_valid = 1'b1;
            chk_excp_cause = fault_cause(chk_access_type);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int i, orv64_paddr_t a, orv64_access_type_t t, cpu_byte_mask_t m);
        req_paddr[i]       = a;
        req_access_type[i] = t;
        req_byte_mask[i]   = m;
    endtask

    task automatic push_exp(int g, orv64_paddr_t a, orv64_access_type_t t, bit d);
        exp_t e;
        e.gnt   = g;
        e.ev    = would_fault(a, d);
        e.cause = e.ev ? fault_cause(t) : '0;
        sb.push_back(e);
    endtask

    task automatic take_resp(output exp_t e, output bit ok);
        if (sb.size() == 0) begin
            ok      = 1'b0;
            e.gnt   = -1;
            e.ev    = 1'b0;
            e.cause = '0;
        end else begin
            ok = 1'b1;
            e  = sb.pop_front();
            if (e.ev) exp_fcnt[e.gnt]++;
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        req_valid   = '0;
        resp_ready  = '0;
        pmp_cfg_chg = 1'b0;
        kill        = 1'b0;
        req_paddr       = '0;
        req_byte_mask   = '0;
        for (int i = 0; i < N; i++) req_access_type[i] = ORV64_ACCESS_FETCH;
        tick();
        tick();
        rst       = 1'b0;
        model_ptr = 0;
        sb.delete();
        for (int i = 0; i < N; i++) exp_fcnt[i] = 0;
    endtask

    task automatic test_fault_cnt(string tag);
`ifdef ORV64_PMP_ARB_FAULT_CNT_EN
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (fault_cnt[i] !== 16'(exp_fcnt[i]))
                $display("FAIL %s fault_cnt[%0d]: got %0d exp %0d", tag, i, fault_cnt[i], exp_fcnt[i]);
            else n_pass++;
        end
`else
        if (tag.len() == 0) $display("fault counter disabled");
`endif
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if (req_ready !== '0 || resp_valid !== '0)
            $display("FAIL reset_handshake: got req_ready=%b resp_valid=%b exp 0/0", req_ready, resp_valid);
        else n_pass++;
        n_checks++;
        if (resp_excp_valid !== 1'b0 || resp_excp_cause !== '0)
            $display("FAIL reset_resp: got excp=%b cause=%0d exp 0/0", resp_excp_valid, resp_excp_cause);
        else n_pass++;
        n_checks++;
        if (chk_paddr_valid !== 1'b0 || chk_paddr !== '0 || chk_access_type !== ORV64_ACCESS_FETCH || chk_byte_mask !== '0)
            $display("FAIL reset_chk: got v=%b a=%h t=%0d m=%h exp all 0", chk_paddr_valid, chk_paddr, chk_access_type, chk_byte_mask);
        else n_pass++;
        test_fault_cnt("reset");
        tick();
    endtask

    task automatic test_single();
        exp_t e;
        bit   ok;
        set_req(ORV64_PMP_REQ_LSU, 56'h0000_0000_8000_1000, ORV64_ACCESS_STORE, 8'hFF);
        req_valid = 3'b010;
        #1;
        n_checks++;
        if (req_ready !== 3'b010) $display("FAIL single_accept: got req_ready=%b exp 010", req_ready);
        else n_pass++;
        push_exp(ORV64_PMP_REQ_LSU, req_paddr[1], req_access_type[1], deny);
        model_ptr = 2;
        tick();
        req_valid = '0;
        #1;
        n_checks++;
        if (chk_paddr_valid !== 1'b1 || chk_paddr !== 56'h0000_0000_8000_1000 ||
            chk_access_type !== ORV64_ACCESS_STORE || chk_byte_mask !== 8'hFF || resp_valid !== '0)
            $display("FAIL single_check: got v=%b a=%h t=%0d m=%h rv=%b exp 1/80001000/2/ff/000",
                     chk_paddr_valid, chk_paddr, chk_access_type, chk_byte_mask, resp_valid);
        else n_pass++;
        tick();
        resp_ready = 3'b010;
        #1;
        take_resp(e, ok);
        n_checks++;
        if (!ok || resp_valid !== 3'b010 || resp_excp_valid !== e.ev || resp_excp_cause !== e.cause || e.cause !== 4'd7)
            $display("FAIL single_resp: got rv=%b excp=%b cause=%0d exp rv=010 excp=%b cause=%0d",
                     resp_valid, resp_excp_valid, resp_excp_cause, e.ev, e.cause);
        else n_pass++;
        n_checks++;
        if (chk_paddr_valid !== 1'b0 || chk_paddr !== '0)
            $display("FAIL single_chk_idle: got v=%b a=%h exp 0/0", chk_paddr_valid, chk_paddr);
        else n_pass++;
        tick();
        resp_ready = '0;
        #1;
        n_checks++;
        if (resp_valid !== '0) $display("FAIL single_done: got rv=%b exp 000", resp_valid);
        else n_pass++;
        test_fault_cnt("single");
        tick();
    endtask

    task automatic test_round_robin();
        int   gnt_seq[$];
        int   gnt_cyc[$];
        int   exp_order[4] = '{0, 1, 2, 0};
        int   g;
        exp_t e;
        bit   ok;
        do_reset();
        set_req(ORV64_PMP_REQ_IFU, 56'h0000_0000_0000_1000, ORV64_ACCESS_FETCH, 8'h0F);
        set_req(ORV64_PMP_REQ_LSU, 56'h0000_0000_8000_2000, ORV64_ACCESS_LOAD,  8'h03);
        set_req(ORV64_PMP_REQ_PTW, 56'h0000_0000_8000_3000, ORV64_ACCESS_LOAD,  8'hFF);
        req_valid  = 3'b111;
        resp_ready = 3'b111;
        for (int cyc = 0; cyc < 30 && gnt_seq.size() < 4; cyc++) begin
            #1;
            if (|resp_valid) begin
                take_resp(e, ok);
                n_checks++;
                if (!ok || resp_valid !== onehot(e.gnt) || resp_excp_valid !== e.ev || resp_excp_cause !== e.cause)
                    $display("FAIL rr_resp: got rv=%b excp=%b cause=%0d exp rv=%b excp=%b cause=%0d",
                             resp_valid, resp_excp_valid, resp_excp_cause, onehot(e.gnt), e.ev, e.cause);
                else n_pass++;
            end
            if (|req_ready) begin
                g = rr_pick(req_valid, model_ptr);
                n_checks++;
                if (req_ready !== onehot(g)) $display("FAIL rr_grant: got req_ready=%b exp %b", req_ready, onehot(g));
                else n_pass++;
                push_exp(g, req_paddr[g], req_access_type[g], deny);
                model_ptr = (g + 1) % N;
                gnt_seq.push_back(oh_idx(req_ready));
                gnt_cyc.push_back(cyc);
            end
            tick();
        end
        req_valid = '0;
        for (int cyc = 0; cyc < 10 && sb.size() > 0; cyc++) begin
            #1;
            if (|resp_valid) begin
                take_resp(e, ok);
                n_checks++;
                if (!ok || resp_valid !== onehot(e.gnt) || resp_excp_valid !== e.ev || resp_excp_cause !== e.cause)
                    $display("FAIL rr_drain: got rv=%b excp=%b cause=%0d exp rv=%b excp=%b cause=%0d",
                             resp_valid, resp_excp_valid, resp_excp_cause, onehot(e.gnt), e.ev, e.cause);
                else n_pass++;
            end
            tick();
        end
        n_checks++;
        if (gnt_seq.size() != 4 || sb.size() != 0)
            $display("FAIL rr_timeout: got grants=%0d pending=%0d exp 4/0", gnt_seq.size(), sb.size());
        else n_pass++;
        for (int k = 0; k < gnt_seq.size(); k++) begin
            n_checks++;
            if (gnt_seq[k] != exp_order[k]) $display("FAIL rr_order[%0d]: got %0d exp %0d", k, gnt_seq[k], exp_order[k]);
            else n_pass++;
            if (k > 0) begin
                n_checks++;
                if (gnt_cyc[k] - gnt_cyc[k-1] != 3)
                    $display("FAIL rr_spacing[%0d]: got %0d exp 3", k, gnt_cyc[k] - gnt_cyc[k-1]);
                else n_pass++;
            end
        end
        resp_ready = '0;
        test_fault_cnt("round_robin");
    endtask

    task automatic test_backpressure();
        int   g;
        exp_t e;
        bit   ok;
        set_req(ORV64_PMP_REQ_IFU, 56'h0000_0000_8000_0040, ORV64_ACCESS_FETCH, 8'h0F);
        req_valid  = 3'b001;
        resp_ready = '0;
        #1;
        g = rr_pick(req_valid, model_ptr);
        n_checks++;
        if (req_ready !== onehot(g)) $display("FAIL bp_accept: got req_ready=%b exp %b", req_ready, onehot(g));
        else n_pass++;
        push_exp(g, req_paddr[g], req_access_type[g], deny);
        model_ptr = (g + 1) % N;
        tick();
        req_valid = 3'b110;
        #1;
        n_checks++;
        if (req_ready !== '0 || chk_paddr_valid !== 1'b1)
            $display("FAIL bp_check: got req_ready=%b chk_v=%b exp 000/1", req_ready, chk_paddr_valid);
        else n_pass++;
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++;
            if (sb.size() == 0 || resp_valid !== onehot(sb[0].gnt) || resp_excp_valid !== sb[0].ev ||
                resp_excp_cause !== sb[0].cause || req_ready !== '0)
                $display("FAIL bp_hold[%0d]: got rv=%b excp=%b cause=%0d rdy=%b exp stable response, rdy=000",
                         k, resp_valid, resp_excp_valid, resp_excp_cause, req_ready);
            else n_pass++;
            tick();
        end
        resp_ready = 3'b001;
        #1;
        take_resp(e, ok);
        n_checks++;
        if (!ok || resp_valid !== onehot(e.gnt) || resp_excp_valid !== e.ev || resp_excp_cause !== e.cause)
            $display("FAIL bp_resp: got rv=%b excp=%b cause=%0d exp rv=%b excp=%b cause=%0d",
                     resp_valid, resp_excp_valid, resp_excp_cause, onehot(e.gnt), e.ev, e.cause);
        else n_pass++;
        tick();
        resp_ready = '0;
        #1;
        g = rr_pick(req_valid, model_ptr);
        n_checks++;
        if (req_ready !== onehot(g)) $display("FAIL bp_idle: got req_ready=%b exp %b", req_ready, onehot(g));
        else n_pass++;
        req_valid = '0;
        tick();
    endtask

    task automatic test_cfg_chg();
        int   g;
        exp_t e;
        bit   ok;
        set_req(ORV64_PMP_REQ_LSU, 56'h0000_0000_8000_5000, ORV64_ACCESS_STORE, 8'hFF);
        req_valid   = 3'b010;
        pmp_cfg_chg = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== '0) $display("FAIL cfg_idle_block: got req_ready=%b exp 000", req_ready);
        else n_pass++;
        tick();
        pmp_cfg_chg = 1'b0;
        #1;
        g = rr_pick(req_valid, model_ptr);
        n_checks++;
        if (req_ready !== onehot(g)) $display("FAIL cfg_accept: got req_ready=%b exp %b", req_ready, onehot(g));
        else n_pass++;
        push_exp(g, req_paddr[g], req_access_type[g], 1'b0);
        model_ptr = (g + 1) % N;
        tick();
        req_valid   = '0;
        pmp_cfg_chg = 1'b1;
        #1;
        n_checks++;
        if (chk_paddr_valid !== 1'b1) $display("FAIL cfg_check1: got chk_v=%b exp 1", chk_paddr_valid);
        else n_pass++;
        tick();
        pmp_cfg_chg = 1'b0;
        deny        = 1'b0;
        #1;
        n_checks++;
        if (chk_paddr_valid !== 1'b1 || resp_valid !== '0)
            $display("FAIL cfg_check2: got chk_v=%b rv=%b exp 1/000", chk_paddr_valid, resp_valid);
        else n_pass++;
        tick();
        resp_ready = 3'b010;
        #1;
        take_resp(e, ok);
        n_checks++;
        if (!ok || resp_valid !== onehot(e.gnt) || resp_excp_valid !== e.ev || resp_excp_cause !== e.cause)
            $display("FAIL cfg_resp: got rv=%b excp=%b cause=%0d exp rv=%b excp=%b cause=%0d",
                     resp_valid, resp_excp_valid, resp_excp_cause, onehot(e.gnt), e.ev, e.cause);
        else n_pass++;
        tick();
        resp_ready = '0;
        deny       = 1'b1;
    endtask

    task automatic test_kill();
        int   g;
        exp_t e;
        bit   ok;
        set_req(ORV64_PMP_REQ_PTW, 56'h0000_0000_8000_9000, ORV64_ACCESS_LOAD, 8'hFF);
        req_valid = 3'b100;
        kill      = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== '0) $display("FAIL kill_idle_block: got req_ready=%b exp 000", req_ready);
        else n_pass++;
        tick();
        kill = 1'b0;
        #1;
        g = rr_pick(req_valid, model_ptr);
        n_checks++;
        if (req_ready !== onehot(g)) $display("FAIL kill_accept1: got req_ready=%b exp %b", req_ready, onehot(g));
        else n_pass++;
        model_ptr = (g + 1) % N;
        tick();
        req_valid = '0;
        kill      = 1'b1;
        #1;
        n_checks++;
        if (chk_paddr_valid !== 1'b1) $display("FAIL kill_in_check: got chk_v=%b exp 1", chk_paddr_valid);
        else n_pass++;
        tick();
        kill = 1'b0;
        #1;
        n_checks++;
        if (resp_valid !== '0 || chk_paddr_valid !== 1'b0)
            $display("FAIL kill_check_drop: got rv=%b chk_v=%b exp 000/0", resp_valid, chk_paddr_valid);
        else n_pass++;
        tick();
        set_req(ORV64_PMP_REQ_IFU, 56'h0000_0000_8000_6000, ORV64_ACCESS_FETCH, 8'h0F);
        req_valid = 3'b001;
        #1;
        g = rr_pick(req_valid, model_ptr);
        n_checks++;
        if (req_ready !== onehot(g)) $display("FAIL kill_accept2: got req_ready=%b exp %b", req_ready, onehot(g));
        else n_pass++;
        model_ptr = (g + 1) % N;
        tick();
        req_valid = '0;
        tick();
        kill = 1'b1;
        #1;
        n_checks++;
        if (resp_valid !== onehot(g)) $display("FAIL kill_in_resp: got rv=%b exp %b", resp_valid, onehot(g));
        else n_pass++;
        tick();
        kill = 1'b0;
        #1;
        n_checks++;
        if (resp_valid !== '0) $display("FAIL kill_resp_drop: got rv=%b exp 000", resp_valid);
        else n_pass++;
        set_req(ORV64_PMP_REQ_PTW, 56'h0000_0000_0000_7000, ORV64_ACCESS_LOAD, 8'hFF);
        req_valid = 3'b100;
        #1;
        g = rr_pick(req_valid, model_ptr);
        n_checks++;
        if (req_ready !== onehot(g)) $display("FAIL kill_accept3: got req_ready=%b exp %b", req_ready, onehot(g));
        else n_pass++;
        push_exp(g, req_paddr[g], req_access_type[g], deny);
        model_ptr = (g + 1) % N;
        tick();
        req_valid = '0;
        tick();
        resp_ready = 3'b100;
        #1;
        take_resp(e, ok);
        n_checks++;
        if (!ok || resp_valid !== onehot(e.gnt) || resp_excp_valid !== e.ev || resp_excp_cause !== e.cause)
            $display("FAIL kill_next_resp: got rv=%b excp=%b cause=%0d exp rv=%b excp=%b cause=%0d",
                     resp_valid, resp_excp_valid, resp_excp_cause, onehot(e.gnt), e.ev, e.cause);
        else n_pass++;
        tick();
        resp_ready = '0;
        test_fault_cnt("kill");
    endtask

    task automatic test_reset_mid();
        int g;
        set_req(ORV64_PMP_REQ_LSU, 56'h0000_0000_8000_8000, ORV64_ACCESS_STORE, 8'hFF);
        req_valid = 3'b010;
        #1;
        g = rr_pick(req_valid, model_ptr);
        n_checks++;
        if (req_ready !== onehot(g)) $display("FAIL rstmid_accept: got req_ready=%b exp %b", req_ready, onehot(g));
        else n_pass++;
        push_exp(g, req_paddr[g], req_access_type[g], deny);
        tick();
        req_valid = '0;
        tick();
        #1;
        n_checks++;
        if (resp_valid !== onehot(g) || resp_excp_valid !== 1'b1)
            $display("FAIL rstmid_in_resp: got rv=%b excp=%b exp %b/1", resp_valid, resp_excp_valid, onehot(g));
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        model_ptr = 0;
        for (int i = 0; i < N; i++) exp_fcnt[i] = 0;
        #1;
        n_checks++;
        if (resp_valid !== '0 || resp_excp_valid !== 1'b0 || resp_excp_cause !== '0 || req_ready !== '0)
            $display("FAIL rstmid_resp_clear: got rv=%b excp=%b cause=%0d rdy=%b exp all 0",
                     resp_valid, resp_excp_valid, resp_excp_cause, req_ready);
        else n_pass++;
        n_checks++;
        if (chk_paddr_valid !== 1'b0 || chk_paddr !== '0 || chk_access_type !== ORV64_ACCESS_FETCH || chk_byte_mask !== '0)
            $display("FAIL rstmid_chk_clear: got v=%b a=%h t=%0d m=%h exp all 0",
                     chk_paddr_valid, chk_paddr, chk_access_type, chk_byte_mask);
        else n_pass++;
        test_fault_cnt("reset_mid");
        req_valid = 3'b110;
        #1;
        g = rr_pick(req_valid, model_ptr);
        n_checks++;
        if (req_ready !== onehot(g)) $display("FAIL rstmid_ptr: got req_ready=%b exp %b", req_ready, onehot(g));
        else n_pass++;
        req_valid = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_cfg_chg();
        test_kill();
        test_reset_mid();
        n_checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_empty: got %0d pending exp 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
